cloop_cmd_bridge: RTL and testbench

- Upstream command stage for the control loop core.
- Accepts single-shot commands (command code + data word) from the CPU-side register interface over a valid/ready channel.
- Drives the loop's four-phase start_cmd/finish_cmd handshake, captures the loop's returned word, and presents it on a valid/ready response channel.
- Bounds each transaction with a timeout so a hung loop cannot stall the CPU.

---
 rtl/cloop_cmd_bridge.sv | 122 ++++++++++++
 tb/tb_cloop_cmd_bridge.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cloop_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cloop_cmd_bridge
// Description : CPU-side command bridge to the control loop. It forwards
//               one command/word per transaction over the loop's four-phase
//               start/finish handshake and returns the loop's word (or a
//               timeout flag) on a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module cloop_cmd_bridge #(
    parameter int CMD_WID     = 8,
    parameter int WORD_WID    = 64,
    parameter int TIMEOUT_WID = 24,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CMD_WID-1:0]  req_cmd,
    input  logic [WORD_WID-1:0] req_word,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WORD_WID-1:0] resp_word,
    output logic                resp_timeout,
    output logic                busy,
    output logic [CMD_WID-1:0]  cmd,
    output logic [WORD_WID-1:0] word_in,
    output logic                start_cmd,
    input  logic                finish_cmd,
    input  logic [WORD_WID-1:0] word_out
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_FIN = 2'd1;
    localparam logic [1:0] S_WAIT_LOW = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    localparam logic [TIMEOUT_WID-1:0] c_timeout_last = TIMEOUT_WID'(TIMEOUT - 1);

    logic [1:0]             r_state;
    logic [TIMEOUT_WID-1:0] r_count;
    logic [CMD_WID-1:0]     r_cmd;
    logic [WORD_WID-1:0]    r_word_in;
    logic [WORD_WID-1:0]    r_resp_word;
    logic                   r_start;
    logic                   r_resp_valid;
    logic                   r_resp_timeout;
    logic                   r_busy;
    logic                   w_req_ready;

    // A finish_cmd still high from an aborted transaction must drain first.
    assign w_req_ready = (r_state == S_IDLE) && !finish_cmd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_cmd          <= '0;
            r_word_in      <= '0;
            r_resp_word    <= '0;
            r_start        <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && w_req_ready) begin
                        r_cmd          <= req_cmd;
                        r_word_in      <= req_word;
                        r_start        <= 1'b1;
                        r_count        <= '0;
                        r_resp_timeout <= 1'b0;
                        r_resp_word    <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= S_WAIT_FIN;
                    end
                end
                S_WAIT_FIN: begin
                    r_count <= r_count + TIMEOUT_WID'(1);
                    // finish_cmd takes priority over an expiring counter
                    if (finish_cmd) begin
                        r_resp_word <= word_out;
                        r_start     <= 1'b0;
                        r_state     <= S_WAIT_LOW;
                    end else if (r_count == c_timeout_last) begin
                        r_start        <= 1'b0;
                        r_resp_timeout <= 1'b1;
                        r_resp_word    <= '0;
                        r_resp_valid   <= 1'b1;
                        r_state        <= S_RESP;
                    end
                end
                S_WAIT_LOW: begin
                    if (!finish_cmd) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready    = w_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_word    = r_resp_word;
    assign resp_timeout = r_resp_timeout;
    assign busy         = r_busy;
    assign cmd          = r_cmd;
    assign word_in      = r_word_in;
    assign start_cmd    = r_start;

endmodule
`default_nettype wire

// File: tb/tb_cloop_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cloop_cmd_bridge
// Description : Self-checking bench for cloop_cmd_bridge with a behavioural
//               loop responder and transaction-level expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cloop_cmd_bridge;

    localparam int CW    = 8;
    localparam int WW    = 64;
    localparam int TW    = 8;
    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_cmd;
    logic [WW-1:0] req_word;
    logic          resp_valid;
    logic          resp_ready;
    logic [WW-1:0] resp_word;
    logic          resp_timeout;
    logic          busy;
    logic [CW-1:0] cmd;
    logic [WW-1:0] word_in;
    logic          start_cmd;
    logic          finish_cmd;
    logic [WW-1:0] word_out;

    int n_tests = 0;
    int n_fail  = 0;

    cloop_cmd_bridge #(
        .CMD_WID     (CW),
        .WORD_WID    (WW),
        .TIMEOUT_WID (TW),
        .TIMEOUT     (TO)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_word     (req_word),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_word    (resp_word),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .cmd          (cmd),
        .word_in      (word_in),
        .start_cmd    (start_cmd),
        .finish_cmd   (finish_cmd),
        .word_out     (word_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
        end
    endtask

    // Present one request as soon as the bridge is ready; returns on the
    // negedge right after the accepting edge.
    task automatic issue(input logic [CW-1:0] c, input logic [WW-1:0] w);
        int t;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = c;
        req_word  = w;
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd   = CW'($urandom);
        req_word  = {$urandom, $urandom};
    endtask

    // Loop model: finish_cmd is sampled high lat+1 edges after acceptance,
    // held hold extra cycles after start_cmd falls. lat >= TO means timeout.
    task automatic serve(input logic [CW-1:0] c, input logic [WW-1:0] w, input int lat,
                         input logic [WW-1:0] rword, input int hold, input int bp);
        int k, hi, low_cnt, k_drop;
        bit fin_up, hold_err, got_resp, bp_err, exp_to;
        logic [WW-1:0] rw_seen;
        k = 0; hi = 0; low_cnt = 0; k_drop = -1;
        fin_up = 0; hold_err = 0; got_resp = 0; bp_err = 0;
        exp_to = (lat > TO - 1);
        word_out = {$urandom, $urandom};
        check("busy_active", busy, 1);
        while (k < 100 && !got_resp) begin
            k++;
            if (resp_valid) begin
                got_resp = 1;
            end else begin
                if (start_cmd) hi++;
                if (cmd !== c || word_in !== w) hold_err = 1;
                if (!fin_up && start_cmd && k == lat + 1) begin
                    finish_cmd = 1'b1;
                    word_out   = rword;
                    fin_up     = 1;
                end else if (fin_up && finish_cmd && !start_cmd) begin
                    if (low_cnt == hold) begin
                        finish_cmd = 1'b0;
                        word_out   = {$urandom, $urandom};
                        k_drop     = k;
                    end else begin
                        low_cnt++;
                    end
                end
                @(negedge clk);
            end
        end
        check("resp_seen", got_resp, 1);
        check("start_hi_cycles", hi, exp_to ? TO : lat + 1);
        check("cmd_word_held", hold_err, 0);
        check("resp_timeout", resp_timeout, exp_to);
        check("resp_word", resp_word, exp_to ? 64'd0 : rword);
        check("resp_latency", k - (exp_to ? 0 : k_drop), exp_to ? TO + 1 : 1);

        // Backpressure with a competing request that must not be taken.
        rw_seen   = resp_word;
        req_valid = 1'b1;
        repeat (bp) begin
            @(negedge clk);
            if (!resp_valid || resp_word !== rw_seen || req_ready || start_cmd || !busy)
                bp_err = 1;
        end
        check("bp_stable", bp_err, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("resp_consumed", {resp_valid, busy, start_cmd}, 3'b000);
    endtask

    initial begin
        int lat, sel;
        logic [CW-1:0] c;
        logic [WW-1:0] w, rw;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = '0;
        req_word   = '0;
        resp_ready = 1'b0;
        finish_cmd = 1'b0;
        word_out   = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {start_cmd, busy, resp_valid, resp_timeout, req_ready}, 5'b00001);
        check("rst_cmd", cmd, 0);
        check("rst_word_in", word_in, 0);
        check("rst_resp_word", resp_word, 0);
        rst = 1'b0;
        @(negedge clk);

        // Normal command with 10 cycles of response backpressure
        issue(8'h03, 64'h1234);
        serve(8'h03, 64'h1234, 5, 64'hABCD, 2, 10);

        // Loop never answers
        issue(8'h5A, 64'hDEAD_BEEF);
        serve(8'h5A, 64'hDEAD_BEEF, NEVER, 64'h0, 0, 2);

        // Late finish after the timeout blocks a queued request
        repeat (3) @(negedge clk);
        finish_cmd = 1'b1;
        word_out   = 64'hBAD0_BAD0;
        req_valid  = 1'b1;
        req_cmd    = 8'h77;
        req_word   = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_fin_block", {req_ready, start_cmd}, 2'b00);
        end
        finish_cmd = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("late_fin_accept", start_cmd, 1);
        serve(8'h77, 64'h0123_4567_89AB_CDEF, 3, 64'h5555, 1, 0);

        // Asynchronous reset in the middle of WAIT_FIN
        issue(8'h11, 64'h42);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst", {start_cmd, busy, resp_valid}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(8'h22, 64'h99);
        serve(8'h22, 64'h99, 0, 64'hC0FFEE, 0, 1);

        // Boundaries: finish on the last allowed edge, one before, one after
        issue(8'h31, 64'h1);
        serve(8'h31, 64'h1, TO - 1, 64'hFEED, 0, 0);
        issue(8'h32, 64'h2);
        serve(8'h32, 64'h2, TO - 2, 64'hF00D, 3, 0);
        issue(8'h33, 64'h3);
        serve(8'h33, 64'h3, TO, 64'h0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      lat = $urandom_range(0, 8);
            else if (sel == 6) lat = TO - 1;
            else if (sel == 7) lat = TO - 2;
            else if (sel == 8) lat = TO;
            else               lat = NEVER;
            c  = CW'($urandom);
            w  = {$urandom, $urandom};
            rw = {$urandom, $urandom};
            issue(c, w);
            serve(c, w, lat, rw, $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
